data_io_wide: RTL and testbench
===============================

# data_io_wide

Parametrised successor of the MiST io-controller download receiver. It takes the io controller's SPI file-transfer stream (commands 0x53/0x54/0x55), oversamples it in the core clock domain, and packs payload bytes into DATA_W-bit words. Words pass through a small FIFO to a stallable req/ack RAM write port, for SDRAM or BRAM loaders that cannot accept a write every byte. It sits between the SPI pins from the io controller and the core's memory arbiter.

## Interface
- ADDR_W, 25, width of byte address and file_size.
- DATA_W, 8, write word width; legal values 8 or 16.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, ≥2.
- INDEX_W, 5, width of menu index.
- clk  in  1  core clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sck, ss, sdi  in  1 each  io-controller SPI, asynchronous to clk; each passes a 2-FF synchroniser.
- downloading  out  1  download active.
- index  out  INDEX_W  last menu index received.
- file_size  out  ADDR_W  bytes accepted in current/last download.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- wr_req  out  1  FIFO head valid.
- wr_ack  in  1  memory accepts head this cycle.
- addr  out  ADDR_W  byte address of head word.
- data  out  DATA_W  head word, first byte in bits [7:0].
- wr_be  out  DATA_W/8  byte enables of head word.

## Operation
- SPI mode 0, MSB first. Bit sampled on each synchronised sck rising edge while ss low. ss high clears the bit counter and marks the next byte as a command byte. A partial byte at ss rise is discarded.
- First byte of each ss frame is the command. Every later byte in that frame is payload for that command. Unknown commands: payload ignored.
- 0x53 FILE_TX, payload bit0=1 (start):
  - addr base and file_size cleared to 0.
  - FIFO flushed; pending partial word discarded; overflow cleared.
  - downloading set.
- 0x53 FILE_TX, payload bit0=0 (end):
  - If a partial 16-bit word is pending, it is pushed with wr_be=2'b01.
  - downloading clears once the FIFO is empty and no partial word is pending.
- 0x54 FILE_TX_DAT: each payload byte is ignored unless downloading=1.
  - DATA_W=8: every byte is one word, wr_be=1.
  - DATA_W=16: even byte goes to bits [7:0]; odd byte goes to [15:8] and completes the word, wr_be=2'b11.
  - A partial word persists across ss frames.
  - Word complete and FIFO not full (or popping the same cycle): word is pushed. Otherwise the word is dropped and overflow is set.
  - file_size increments by 1 per accepted byte. Bytes of a dropped word are not counted. file_size saturates at all-ones.
- 0x55 FILE_INDEX: index <= payload[INDEX_W-1:0]. Index is independent of downloading.
- Write port:
  - wr_req = FIFO non-empty. addr, data and wr_be are stable while wr_req=1 and wr_ack=0.
  - wr_req&&wr_ack pops the head.
  - Each FIFO entry stores its own byte address: a running write pointer advancing DATA_W/8 per pushed word, wrapping modulo 2^ADDR_W.
- Reset values: downloading=0, index=0, file_size=0, overflow=0, wr_req=0, addr=0, data=0, wr_be=0. FIFO empty, SPI bit counter idle, command byte expected.

## Timing
- Requirement: clk frequency ≥ 4× sck frequency; sck high and low phases each ≥ 2 clk.
- Byte completion is registered 3 clk after the sck edge of bit 0 (2 sync + 1 edge detect). The push occurs in that same cycle; wr_req rises the following cycle.
- downloading rises 1 clk after the start command byte completes. It falls 1 clk after the final pop, or 1 clk after end completes if the FIFO is already empty.
- FIFO throughput is one push and one pop per clk. Push and pop in the same cycle when full is legal and loses nothing. Pop when empty is impossible because wr_req=0.
- A start command arriving while the FIFO is non-empty flushes it. wr_req drops the cycle after the flush even if wr_ack was pending.
- reset_n low mid-transfer: all state cleared immediately. After release, the next ss-low byte is treated as a command.
- ss rise mid-byte: the partial byte is dropped. The next frame's first byte is a command.

## Test plan
- DATA_W=8, wr_ack tied 1: start, bytes 0x11,0x22,0x33, end -> writes (0,0x11),(1,0x22),(2,0x33), each wr_be=1; file_size=3; downloading falls after the last write.
- DATA_W=16: start, bytes 0xAA,0xBB,0xCC, end -> writes (0,0xBBAA,be=11) and (2,0x00CC or don't-care high byte,be=01); file_size=3.
- FIFO_DEPTH=4, wr_ack=0: stream 6 bytes -> 4 entries held, overflow=1, file_size=4. Raise wr_ack -> exactly 4 writes at addr 0..3.
- Command 0x55 with payload 0x23 (INDEX_W=5) -> index=5'h03. Unknown command 0x99 followed by data -> no writes, no state change.
- Reset mid-download, and ss rising after 4 bits of a data byte -> all outputs at reset values; partial byte produces no write; the next frame decodes its first byte as a command.
- Start received while 3 words are queued with wr_ack=0 -> wr_req drops, addr restarts at 0, overflow cleared.

Source files
------------

// File: rtl/data_io_wide.sv
// Download receiver for the io-controller SPI file-transfer stream: oversamples SPI,
// packs payload bytes into DATA_W-bit words and queues them for a stallable RAM write port.
module data_io_wide #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  sdi,
  output logic                  downloading,
  output logic [INDEX_W-1:0]    index,
  output logic [ADDR_W-1:0]     file_size,
  output logic                  overflow,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     data,
  output logic [DATA_W/8-1:0]   wr_be
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] CMD_FILE_TX     = 8'h53;
  localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

  logic [1:0] sck_sync, ss_sync, sdi_sync;
  logic       sck_prev;
  logic       sck_rise;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       is_cmd;
  logic [7:0] cmd;

  logic is_payload, start_cmd, end_cmd, dat_cmd, idx_cmd;

  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic [BE_W-1:0]   push_be;
  logic [1:0]        push_bytes;
  logic              half_valid;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [BE_W-1:0]   mem_be   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx, rd_idx;
  logic [CNT_W-1:0]  count, count_next;
  logic              pop, do_push, fifo_full;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   fs_sum;
  logic              end_pending;

  assign sck_rise = sck_sync[1] & ~sck_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync <= '0;
      ss_sync  <= 2'b11;
      sdi_sync <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ss_sync  <= {ss_sync[0], ss};
      sdi_sync <= {sdi_sync[0], sdi};
      sck_prev <= sck_sync[1];
    end
  end

  // Bit assembly; ss high abandons any partial byte and re-arms command decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      is_cmd     <= 1'b1;
      cmd        <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (ss_sync[1]) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift   <= {shift[5:0], sdi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {shift, sdi_sync[1]};
          byte_valid <= 1'b1;
        end
      end
      if (ss_sync[1]) begin
        is_cmd <= 1'b1;
      end else if (byte_valid && is_cmd) begin
        is_cmd <= 1'b0;
      end
      if (byte_valid && is_cmd) begin
        cmd <= rx_byte;
      end
    end
  end

  assign is_payload = byte_valid && !is_cmd;
  assign start_cmd  = is_payload && (cmd == CMD_FILE_TX) && rx_byte[0];
  assign end_cmd    = is_payload && (cmd == CMD_FILE_TX) && !rx_byte[0];
  assign dat_cmd    = is_payload && (cmd == CMD_FILE_TX_DAT) && downloading;
  assign idx_cmd    = is_payload && (cmd == CMD_FILE_INDEX);

  generate
    if (DATA_W == 8) begin : g_w8
      assign half_valid = 1'b0;
      always_comb begin
        push_req   = dat_cmd;
        push_data  = DATA_W'(rx_byte);
        push_be    = BE_W'(1);
        push_bytes = 2'd1;
      end
    end else begin : g_w16
      logic [7:0] half_byte;
      logic       half_q;

      // The low byte waits here, across frames, until its partner byte or an end command.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          half_q    <= 1'b0;
          half_byte <= '0;
        end else if (start_cmd || end_cmd) begin
          half_q <= 1'b0;
        end else if (dat_cmd) begin
          if (!half_q) begin
            half_byte <= rx_byte;
            half_q    <= 1'b1;
          end else begin
            half_q <= 1'b0;
          end
        end
      end

      assign half_valid = half_q;

      always_comb begin
        push_req   = 1'b0;
        push_data  = '0;
        push_be    = '0;
        push_bytes = 2'd0;
        if (dat_cmd && half_q) begin
          push_req   = 1'b1;
          push_data  = DATA_W'({rx_byte, half_byte});
          push_be    = BE_W'(2'b11);
          push_bytes = 2'd2;
        end else if (end_cmd && half_q) begin
          push_req   = 1'b1;
          push_data  = DATA_W'({8'h00, half_byte});
          push_be    = BE_W'(2'b01);
          push_bytes = 2'd1;
        end
      end
    end
  endgenerate

  assign wr_req    = (count != '0);
  assign pop       = wr_req && wr_ack;
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign do_push   = push_req && (!fifo_full || pop);

  always_comb begin
    count_next = count;
    if (start_cmd) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(do_push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_idx] <= push_data;
      mem_addr[wr_idx] <= wptr;
      mem_be[wr_idx]   <= push_be;
    end
  end

  // A start command flushes the queue outright, even with a write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (start_cmd) begin
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        if (do_push) wr_idx <= wr_idx + PTR_W'(1);
        if (pop)     rd_idx <= rd_idx + PTR_W'(1);
      end
    end
  end

  assign fs_sum = {1'b0, file_size} + (ADDR_W + 1)'(push_bytes);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      file_size   <= '0;
      overflow    <= 1'b0;
      downloading <= 1'b0;
      end_pending <= 1'b0;
      index       <= '0;
    end else begin
      if (start_cmd) begin
        wptr      <= '0;
        file_size <= '0;
        overflow  <= 1'b0;
      end else if (do_push) begin
        wptr      <= wptr + ADDR_W'(BE_W);
        file_size <= fs_sum[ADDR_W] ? '1 : fs_sum[ADDR_W-1:0];
      end else if (push_req) begin
        overflow <= 1'b1;
      end

      // Downloading stays up after the end command until the queue has fully drained.
      if (start_cmd) begin
        downloading <= 1'b1;
        end_pending <= 1'b0;
      end else if ((end_cmd || (end_pending && !half_valid && !dat_cmd)) && count_next == '0) begin
        downloading <= 1'b0;
        end_pending <= 1'b0;
      end else if (end_cmd) begin
        end_pending <= 1'b1;
      end

      if (idx_cmd) begin
        index <= rx_byte[INDEX_W-1:0];
      end
    end
  end

  assign addr  = wr_req ? mem_addr[rd_idx] : '0;
  assign data  = wr_req ? mem_data[rd_idx] : '0;
  assign wr_be = wr_req ? mem_be[rd_idx]   : '0;

endmodule

// File: tb/tb_data_io_wide.sv
// Directed bench for data_io_wide: one 8-bit and one 16-bit instance share the SPI stream,
// each with its own write-acknowledge and write log.
module tb_data_io_wide;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0, ss = 1'b1, sdi = 1'b0;

  logic        dl8, ovf8, wr_req8, wr_ack8;
  logic [4:0]  index8;
  logic [24:0] fs8, addr8;
  logic [7:0]  data8;
  logic [0:0]  be8;

  logic        dl16, ovf16, wr_req16, wr_ack16;
  logic [4:0]  index16;
  logic [24:0] fs16, addr16;
  logic [15:0] data16;
  logic [1:0]  be16;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_q [$];
  logic [24:0] w8_addr [$];
  logic [7:0]  w8_data [$];
  logic [0:0]  w8_be [$];
  logic [24:0] w16_addr [$];
  logic [15:0] w16_data [$];
  logic [1:0]  w16_be [$];

  always #5 clk = ~clk;

  data_io_wide #(.ADDR_W(25), .DATA_W(8), .FIFO_DEPTH(4), .INDEX_W(5)) dut8 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl8), .index(index8), .file_size(fs8), .overflow(ovf8),
    .wr_req(wr_req8), .wr_ack(wr_ack8), .addr(addr8), .data(data8), .wr_be(be8)
  );

  data_io_wide #(.ADDR_W(25), .DATA_W(16), .FIFO_DEPTH(4), .INDEX_W(5)) dut16 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl16), .index(index16), .file_size(fs16), .overflow(ovf16),
    .wr_req(wr_req16), .wr_ack(wr_ack16), .addr(addr16), .data(data16), .wr_be(be16)
  );

  // Log every accepted write; the handshake completes on the following rising edge.
  always @(negedge clk) begin
    #2;
    if (wr_req8 && wr_ack8) begin
      w8_addr.push_back(addr8);
      w8_data.push_back(data8);
      w8_be.push_back(be8);
    end
    if (wr_req16 && wr_ack16) begin
      w16_addr.push_back(addr16);
      w16_data.push_back(data16);
      w16_be.push_back(be16);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic spiBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  // One ss frame: command byte followed by whatever is in tx_q.
  task automatic applyStimulus(input logic [7:0] cmd);
    ss = 1'b0;
    #40;
    spiBits(cmd, 8);
    foreach (tx_q[i]) spiBits(tx_q[i], 8);
    tx_q.delete();
    #40 ss = 1'b1;
    #120;
  endtask

  task automatic clearLogs();
    w8_addr.delete(); w8_data.delete(); w8_be.delete();
    w16_addr.delete(); w16_data.delete(); w16_be.delete();
  endtask

  task automatic checkW8(input string tag, input logic [24:0] a, input logic [7:0] d);
    if (w8_addr.size() > 0) begin
      checkOutput({tag, " addr"}, 32'(w8_addr.pop_front()), 32'(a));
      checkOutput({tag, " data"}, 32'(w8_data.pop_front()), 32'(d));
      checkOutput({tag, " be"},   32'(w8_be.pop_front()),   32'h1);
    end
  endtask

  initial begin
    wr_ack8  = 1'b1;
    wr_ack16 = 1'b1;
    #22;
    checkOutput("rst dl8",    32'(dl8),     32'h0);
    checkOutput("rst index8", 32'(index8),  32'h0);
    checkOutput("rst fs8",    32'(fs8),     32'h0);
    checkOutput("rst ovf8",   32'(ovf8),    32'h0);
    checkOutput("rst req8",   32'(wr_req8), 32'h0);
    checkOutput("rst addr8",  32'(addr8),   32'h0);
    checkOutput("rst data8",  32'(data8),   32'h0);
    checkOutput("rst be8",    32'(be8),     32'h0);
    checkOutput("rst req16",  32'(wr_req16),32'h0);
    #30 reset_n = 1'b1;
    #100;

    // Basic download, both widths, acknowledge held high.
    tx_q = '{8'h01}; applyStimulus(8'h53);
    checkOutput("start dl8",  32'(dl8),  32'h1);
    checkOutput("start dl16", 32'(dl16), 32'h1);
    tx_q = '{8'h11, 8'h22, 8'h33}; applyStimulus(8'h54);
    tx_q = '{8'h00}; applyStimulus(8'h53);
    #200;
    checkOutput("end dl8",  32'(dl8),  32'h0);
    checkOutput("end dl16", 32'(dl16), 32'h0);
    checkOutput("end fs8",  32'(fs8),  32'd3);
    checkOutput("end fs16", 32'(fs16), 32'd3);
    checkOutput("w8 count", 32'(w8_addr.size()), 32'd3);
    checkW8("w8 #0", 25'd0, 8'h11);
    checkW8("w8 #1", 25'd1, 8'h22);
    checkW8("w8 #2", 25'd2, 8'h33);
    checkOutput("w16 count", 32'(w16_addr.size()), 32'd2);
    if (w16_addr.size() > 0) begin
      checkOutput("w16 #0 addr", 32'(w16_addr.pop_front()), 32'd0);
      checkOutput("w16 #0 data", 32'(w16_data.pop_front()), 32'h2211);
      checkOutput("w16 #0 be",   32'(w16_be.pop_front()),   32'h3);
    end
    if (w16_addr.size() > 0) begin
      checkOutput("w16 #1 addr", 32'(w16_addr.pop_front()), 32'd2);
      checkOutput("w16 #1 lo",   32'(w16_data.pop_front() & 16'h00FF), 32'h33);
      checkOutput("w16 #1 be",   32'(w16_be.pop_front()),   32'h1);
    end

    // Stalled write port: 8-bit instance overflows, 16-bit instance holds 3 words.
    @(negedge clk);
    wr_ack8 = 1'b0;
    wr_ack16 = 1'b0;
    clearLogs();
    tx_q = '{8'h01}; applyStimulus(8'h53);
    tx_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46}; applyStimulus(8'h54);
    checkOutput("stall w8 none", 32'(w8_addr.size()), 32'd0);
    checkOutput("stall ovf8",    32'(ovf8),    32'h1);
    checkOutput("stall fs8",     32'(fs8),     32'd4);
    checkOutput("stall req8",    32'(wr_req8), 32'h1);
    checkOutput("stall addr8",   32'(addr8),   32'd0);
    checkOutput("stall data8",   32'(data8),   32'h41);
    checkOutput("stall ovf16",   32'(ovf16),   32'h0);
    checkOutput("stall fs16",    32'(fs16),    32'd6);
    checkOutput("stall data16",  32'(data16),  32'h4241);
    checkOutput("stall be16",    32'(be16),    32'h3);
    @(negedge clk);
    wr_ack8 = 1'b1;
    repeat (12) @(negedge clk);
    #4;
    checkOutput("drain w8 count", 32'(w8_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkW8($sformatf("drain #%0d", i), 25'(i), 8'(8'h41 + i));
    checkOutput("drain req8", 32'(wr_req8), 32'h0);
    checkOutput("drain dl8",  32'(dl8),     32'h1);

    // Start while the 16-bit queue holds three stalled words.
    clearLogs();
    tx_q = '{8'h01}; applyStimulus(8'h53);
    checkOutput("flush req16", 32'(wr_req16), 32'h0);
    checkOutput("flush ovf16", 32'(ovf16),    32'h0);
    checkOutput("flush fs16",  32'(fs16),     32'd0);
    checkOutput("flush ovf8",  32'(ovf8),     32'h0);
    checkOutput("flush none16",32'(w16_addr.size()), 32'd0);
    tx_q = '{8'h77, 8'h88}; applyStimulus(8'h54);
    checkOutput("reload addr16", 32'(addr16), 32'd0);
    checkOutput("reload data16", 32'(data16), 32'h8877);
    checkOutput("reload fs16",   32'(fs16),   32'd2);
    @(negedge clk);
    wr_ack16 = 1'b1;
    repeat (6) @(negedge clk);
    #4;
    checkOutput("reload w16 count", 32'(w16_addr.size()), 32'd1);
    checkOutput("reload w8 count",  32'(w8_addr.size()),  32'd2);
    checkW8("reload w8 #0", 25'd0, 8'h77);
    checkW8("reload w8 #1", 25'd1, 8'h88);

    // Index command, then an unknown command whose payload must be ignored.
    clearLogs();
    tx_q = '{8'h23}; applyStimulus(8'h55);
    checkOutput("index8",  32'(index8),  32'h03);
    checkOutput("index16", 32'(index16), 32'h03);
    tx_q = '{8'h12, 8'h34}; applyStimulus(8'h99);
    #100;
    checkOutput("unk w8",    32'(w8_addr.size()),  32'd0);
    checkOutput("unk w16",   32'(w16_addr.size()), 32'd0);
    checkOutput("unk fs8",   32'(fs8),    32'd2);
    checkOutput("unk fs16",  32'(fs16),   32'd2);
    checkOutput("unk index", 32'(index8), 32'h03);

    // ss rising after 4 bits of a data byte.
    ss = 1'b0;
    #40;
    spiBits(8'h54, 8);
    spiBits(8'h5A, 8);
    spiBits(8'hF0, 4);
    #40 ss = 1'b1;
    #200;
    checkOutput("partial w8 count", 32'(w8_addr.size()), 32'd1);
    checkW8("partial w8", 25'd2, 8'h5A);
    checkOutput("partial fs8",  32'(fs8),  32'd3);
    checkOutput("partial w16",  32'(w16_addr.size()), 32'd0);
    checkOutput("partial fs16", 32'(fs16), 32'd2);
    tx_q = '{8'h0A}; applyStimulus(8'h55);
    checkOutput("after partial index", 32'(index8), 32'h0A);

    // Reset in the middle of a frame.
    ss = 1'b0;
    #40;
    spiBits(8'h54, 8);
    spiBits(8'hC3, 4);
    reset_n = 1'b0;
    #30;
    checkOutput("midrst dl8",   32'(dl8),     32'h0);
    checkOutput("midrst index", 32'(index8),  32'h0);
    checkOutput("midrst fs8",   32'(fs8),     32'h0);
    checkOutput("midrst req8",  32'(wr_req8), 32'h0);
    checkOutput("midrst dl16",  32'(dl16),    32'h0);
    checkOutput("midrst fs16",  32'(fs16),    32'h0);
    ss = 1'b1;
    #50 reset_n = 1'b1;
    #100;
    clearLogs();
    tx_q = '{8'h15}; applyStimulus(8'h55);
    checkOutput("postrst index8",  32'(index8),  32'h15);
    checkOutput("postrst index16", 32'(index16), 32'h15);
    tx_q = '{8'h66}; applyStimulus(8'h54);
    #100;
    checkOutput("postrst w8",  32'(w8_addr.size()),  32'd0);
    checkOutput("postrst w16", 32'(w16_addr.size()), 32'd0);
    checkOutput("postrst fs8", 32'(fs8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
